dsi_tx_scheduler: RTL

//  Sits upstream of dsi_lanes_controller, clk_sys domain. Sequences lane/clock power-up and power-down.

---
 rtl/dsi_tx_sched_pkg.sv | 13 +
 rtl/dsi_tx_power_seq.sv | 64 ++++++
 rtl/dsi_tx_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dsi_tx_sched_pkg.sv
// dsi_tx_sched_pkg: shared state/grant types and counter-width helper for the DSI TX scheduler
package dsi_tx_sched_pkg;
   typedef enum logic [3:0] {
      S_OFF, S_LANES_UP, S_CLK_UP, S_IDLE, S_SEND, S_FLUSH, S_GAP, S_CLK_DOWN, S_LANES_DOWN
   } sched_state_t;
   typedef enum logic {GNT_VID, GNT_CMD} grant_t;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   // Width of a counter that runs 0..n-1
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/dsi_tx_power_seq.sv
// dsi_tx_power_seq: lane/clock power-up and power-down sequencer with ready timeout
//   i_up_req / i_down_req      start power-up from OFF / power-down from IDLE
//   i_lines_ready/i_clock_ready  handshakes from the lane controller
//   o_lines_enable/o_clock_enable  power controls (decoded from registered state)
//   o_up_done  high the cycle the sequencer moves CLK_UP -> IDLE
//   o_off      sequencer is in OFF
//   o_timeout  1-cycle pulse when a ready wait expires (sequencer returns to OFF)
module dsi_tx_power_seq
   import dsi_tx_sched_pkg::*;
#(
   parameter int READY_TIMEOUT = 4096
) (
   input  logic i_clk_sys,
   input  logic i_rst_n,
   input  logic i_up_req,
   input  logic i_down_req,
   input  logic i_lines_ready,
   input  logic i_clock_ready,
   output logic o_lines_enable,
   output logic o_clock_enable,
   output logic o_up_done,
   output logic o_off,
   output logic o_timeout
);
   localparam int TW = cnt_w(READY_TIMEOUT);
   sched_state_t  r_state, w_next;
   logic [TW-1:0] r_cnt;
   logic          w_wait;
   assign w_wait = r_state inside {S_LANES_UP, S_CLK_UP, S_CLK_DOWN, S_LANES_DOWN};
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_OFF;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_next != r_state) ? '0 : r_cnt + TW'(w_wait);
      end
   end
   always_comb begin
      w_next    = r_state;
      o_up_done = 1'b0;
      o_timeout = 1'b0;
      case (r_state)
         S_OFF:        if (i_up_req) w_next = S_LANES_UP;
         S_LANES_UP:   if (i_lines_ready) w_next = S_CLK_UP;
         S_CLK_UP:     if (i_clock_ready) begin
                          w_next    = S_IDLE;
                          o_up_done = 1'b1;
                       end
         S_IDLE:       if (i_down_req) w_next = S_CLK_DOWN;
         S_CLK_DOWN:   if (!i_clock_ready) w_next = S_LANES_DOWN;
         S_LANES_DOWN: if (!i_lines_ready) w_next = S_OFF;
         default:      w_next = S_OFF;
      endcase
      // A ready arriving on the expiry cycle still wins over the timeout
      if (w_wait && w_next == r_state && r_cnt == TW'(READY_TIMEOUT - 1)) begin
         w_next    = S_OFF;
         o_timeout = 1'b1;
      end
   end
   assign o_lines_enable = r_state inside {S_LANES_UP, S_CLK_UP, S_IDLE, S_CLK_DOWN};
   assign o_clock_enable = r_state inside {S_CLK_UP, S_IDLE};
   assign o_off          = r_state == S_OFF;
endmodule

// File: rtl/dsi_tx_scheduler.sv
// dsi_tx_scheduler: power sequencing, video/command arbitration and packet gap control
//   in front of the DSI lane controller (clk_sys domain).
//   Ports: i_enable, i_cfg_lanes_number; video and command sources (valid/data/strb/last in,
//   ready out, plus i_cmd_lpm); o_iface_* word interface with i_iface_data_rqst;
//   o_lines_enable/o_clock_enable with i_lines_ready/i_clock_ready; o_busy, o_err_underrun, o_err_timeout.
//   Optional macro IDLE_POWERDOWN_EN: power down after IDLE_TIMEOUT idle cycles in IDLE.
module dsi_tx_scheduler
   import dsi_tx_sched_pkg::*;
#(
   parameter int GAP_CYCLES    = 16,
   parameter int READY_TIMEOUT = 4096,
   parameter int IDLE_TIMEOUT  = 1024,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic              i_clk_sys,
   input  logic              i_rst_n,
   input  logic              i_enable,
   input  logic [1:0]        i_cfg_lanes_number,
   input  logic              i_vid_valid,
   input  logic [DATA_W-1:0] i_vid_data,
   input  logic [STRB_W-1:0] i_vid_strb,
   input  logic              i_vid_last,
   output logic              o_vid_ready,
   input  logic              i_cmd_valid,
   input  logic [DATA_W-1:0] i_cmd_data,
   input  logic [STRB_W-1:0] i_cmd_strb,
   input  logic              i_cmd_last,
   output logic              o_cmd_ready,
   input  logic              i_cmd_lpm,
   output logic [DATA_W-1:0] o_iface_write_data,
   output logic [STRB_W-1:0] o_iface_write_strb,
   output logic              o_iface_write_rqst,
   output logic              o_iface_last_word,
   input  logic              i_iface_data_rqst,
   output logic              o_iface_lpm_en,
   output logic [1:0]        o_reg_lanes_number,
   output logic              o_lines_enable,
   output logic              o_clock_enable,
   input  logic              i_lines_ready,
   input  logic              i_clock_ready,
   output logic              o_busy,
   output logic              o_err_underrun,
   output logic              o_err_timeout
);
   localparam int GW = cnt_w(GAP_CYCLES);
   localparam int SW = cnt_w(STARVE_LIMIT + 1);
   sched_state_t      r_state, w_next;
   grant_t            r_gnt, w_gnt;
   logic [GW-1:0]     r_gap;
   logic [SW-1:0]     r_starve;
   logic [DATA_W-1:0] r_data, w_src_data;
   logic [STRB_W-1:0] r_strb, w_src_strb;
   logic [1:0]        r_lanes;
   logic r_rqst, r_last, r_lpm, r_en_d, r_err_ur, r_err_to;
   logic w_src_valid, w_src_last, w_any, w_down, w_pop, w_load, w_grant, w_under, w_clr;
   logic w_up_req, w_up_done, w_pwr_off, w_timeout, w_idle_to;
   dsi_tx_power_seq #(.READY_TIMEOUT(READY_TIMEOUT)) u_pwr (
      .i_clk_sys      (i_clk_sys),
      .i_rst_n        (i_rst_n),
      .i_up_req       (w_up_req),
      .i_down_req     (r_state == S_IDLE && w_down),
      .i_lines_ready  (i_lines_ready),
      .i_clock_ready  (i_clock_ready),
      .o_lines_enable (o_lines_enable),
      .o_clock_enable (o_clock_enable),
      .o_up_done      (w_up_done),
      .o_off          (w_pwr_off),
      .o_timeout      (w_timeout)
   );
`ifdef IDLE_POWERDOWN_EN
   localparam int IW = cnt_w(IDLE_TIMEOUT);
   logic [IW-1:0] r_idle;
   logic          r_auto_off;
   assign w_idle_to = r_state == S_IDLE && !w_any && r_idle == IW'(IDLE_TIMEOUT - 1);
   // After an idle power-down, stay off until a source has something to send
   assign w_up_req  = i_enable && !r_err_to && (!r_auto_off || w_any);
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idle     <= '0;
         r_auto_off <= 1'b0;
      end else begin
         r_idle     <= (r_state == S_IDLE && !w_any) ? r_idle + IW'(1) : '0;
         r_auto_off <= w_idle_to || (r_auto_off && i_enable && !(w_pwr_off && w_any));
      end
   end
`else
   assign w_idle_to = 1'b0;
   assign w_up_req  = i_enable && !r_err_to;
`endif
   // A timeout leaves the link off until enable is toggled, which also clears the error
   assign w_clr       = i_enable && !r_en_d;
   assign w_any       = i_vid_valid || i_cmd_valid;
   assign w_down      = !i_enable || w_idle_to;
   assign w_gnt       = (r_state != S_IDLE) ? r_gnt :
                        (i_cmd_valid && (!i_vid_valid || r_starve == SW'(STARVE_LIMIT))) ? GNT_CMD : GNT_VID;
   assign w_src_valid = (w_gnt == GNT_CMD) ? i_cmd_valid : i_vid_valid;
   assign w_src_last  = (w_gnt == GNT_CMD) ? i_cmd_last  : i_vid_last;
   assign w_src_data  = (w_gnt == GNT_CMD) ? i_cmd_data  : i_vid_data;
   assign w_src_strb  = (w_gnt == GNT_CMD) ? i_cmd_strb  : i_vid_strb;
   assign w_grant     = r_state == S_IDLE && !w_down && w_any;
   assign w_pop       = w_grant || (r_state == S_SEND && i_iface_data_rqst && w_src_valid) ||
                        (r_state == S_FLUSH && w_src_valid);
   assign w_load      = w_pop && r_state != S_FLUSH;
   assign w_under     = r_state == S_SEND && i_iface_data_rqst && !w_src_valid;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_OFF:   if (w_up_done) w_next = S_IDLE;
         S_IDLE:  if (w_down) w_next = S_OFF;
                  else if (w_any) w_next = w_src_last ? S_GAP : S_SEND;
         S_SEND:  if (w_under) w_next = S_FLUSH;
                  else if (w_load && w_src_last) w_next = S_GAP;
         S_FLUSH: if (w_pop && w_src_last) w_next = S_GAP;
         S_GAP:   if (r_gap == GW'(GAP_CYCLES - 1)) w_next = S_IDLE;
         default: w_next = S_OFF;
      endcase
   end
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_OFF;
         r_gnt    <= GNT_VID;
         r_gap    <= '0;
         r_starve <= '0;
         r_data   <= '0;
         r_strb   <= '0;
         r_rqst   <= 1'b0;
         r_last   <= 1'b0;
         r_lpm    <= 1'b0;
         r_en_d   <= 1'b0;
         r_err_ur <= 1'b0;
         r_err_to <= 1'b0;
         r_lanes  <= '0;
      end else begin
         r_state  <= w_next;
         r_gnt    <= w_gnt;
         r_gap    <= (r_state == S_GAP) ? r_gap + GW'(1) : '0;
         r_rqst   <= w_grant;
         r_last   <= w_load ? w_src_last : w_under;
         r_en_d   <= i_enable;
         r_err_ur <= (r_err_ur && !w_clr) || w_under;
         r_err_to <= (r_err_to && !w_clr) || w_timeout;
         if (w_load || w_under) begin
            r_data <= w_load ? w_src_data : '0;
            r_strb <= w_load ? w_src_strb : '0;
         end
         if (w_grant) begin
            r_lpm    <= (w_gnt == GNT_CMD) && i_cmd_lpm;
            r_starve <= (w_gnt == GNT_CMD) ? '0 :
                        (i_cmd_valid && r_starve != SW'(STARVE_LIMIT)) ? r_starve + SW'(1) : r_starve;
         end
         if (w_pwr_off) r_lanes <= i_cfg_lanes_number;
      end
   end
   assign o_vid_ready        = w_pop && w_gnt == GNT_VID;
   assign o_cmd_ready        = w_pop && w_gnt == GNT_CMD;
   assign o_iface_write_data = r_data;
   assign o_iface_write_strb = r_strb;
   assign o_iface_write_rqst = r_rqst;
   assign o_iface_last_word  = r_last;
   assign o_iface_lpm_en     = r_lpm;
   assign o_reg_lanes_number = r_lanes;
   assign o_busy             = !w_pwr_off && r_state != S_IDLE;
   assign o_err_underrun     = r_err_ur;
   assign o_err_timeout      = r_err_to;
endmodule
